// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

  localparam logic UART_IDLE = 1'b1;

  // Width of a counter that counts 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rx_frame.sv
// 8N1-style frame recovery: rx synchronizer, bit-timing FSM and data shift register.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_PULSE = 4,
  parameter int unsigned BITS_PER_WORD    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx,
  output logic [BITS_PER_WORD-1:0] word,
  output logic                     word_valid,
  output logic                     frame_err
);

  localparam int unsigned CNT_W = cnt_width(CLOCKS_PER_PULSE);
  localparam int unsigned BIT_W = cnt_width(BITS_PER_WORD);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLOCKS_PER_PULSE - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(BITS_PER_WORD - 1);

  rx_state_t state, state_next;
  logic rx_meta, rx_s;
  logic [CNT_W-1:0] cnt;
  logic [BIT_W-1:0] bit_idx;
  logic [BITS_PER_WORD-1:0] shift;
  logic tick, half_tick;

  assign tick      = (cnt == FULL_LAST);
  assign half_tick = (cnt == HALF_LAST);
  assign word      = shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= UART_IDLE;
      rx_s    <= UART_IDLE;
      state   <= IDLE;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      state   <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!rx_s) state_next = START;
      START:   if (half_tick) state_next = rx_s ? IDLE : DATA;
      DATA:    if (tick && bit_idx == LAST_BIT) state_next = STOP;
      STOP:    if (tick) state_next = rx_s ? IDLE : BREAK;
      BREAK:   if (rx_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    word_valid = 1'b0;
    frame_err  = 1'b0;
    if (state == STOP && tick) begin
      word_valid = rx_s;
      frame_err  = !rx_s;
    end
  end

  // Bit-clock counter restarts at each sampling point so DATA/STOP sample mid-bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        START:      cnt <= half_tick ? '0 : cnt + 1'b1;
        DATA, STOP: cnt <= tick ? '0 : cnt + 1'b1;
        default:    cnt <= '0;
      endcase
      if (state == DATA) begin
        if (tick) begin
          shift[bit_idx] <= rx_s;
          bit_idx        <= (bit_idx == LAST_BIT) ? '0 : bit_idx + 1'b1;
        end
      end else begin
        bit_idx <= '0;
      end
    end
  end

endmodule

// File: rtl/uart_rx_packer.sv
// Packs received UART frames into W_OUT-bit words on a valid/ready master port.
module uart_rx_packer
  import uart_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_PULSE = 4,
  parameter int unsigned BITS_PER_WORD    = 8,
  parameter int unsigned W_OUT            = 576
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  output logic [W_OUT-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             frame_err,
  output logic             overflow
);

  localparam int unsigned N_WORDS = W_OUT / BITS_PER_WORD;
  localparam int unsigned IW_W    = cnt_width(N_WORDS);
  localparam logic [IW_W-1:0] LAST_IW = IW_W'(N_WORDS - 1);

  logic [BITS_PER_WORD-1:0] word;
  logic word_valid;
  logic [W_OUT-1:0] asm_buf;
  logic [IW_W-1:0] iw;
  logic asm_full, load, drop, accept;

  uart_rx_frame #(
    .CLOCKS_PER_PULSE(CLOCKS_PER_PULSE),
    .BITS_PER_WORD   (BITS_PER_WORD)
  ) u_frame (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .word      (word),
    .word_valid(word_valid),
    .frame_err (frame_err)
  );

  // A frame arriving while the full buffer is being moved out is kept, not dropped.
  assign load     = asm_full && (!m_valid || m_ready);
  assign drop     = word_valid && asm_full && !load;
  assign accept   = word_valid && !drop;
  assign overflow = drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_buf  <= '0;
      iw       <= '0;
      asm_full <= 1'b0;
    end else begin
      if (accept) begin
        asm_buf[iw*BITS_PER_WORD +: BITS_PER_WORD] <= word;
        iw <= (iw == LAST_IW) ? '0 : iw + 1'b1;
      end
      asm_full <= (asm_full && !load) || (accept && iw == LAST_IW);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data  <= '0;
      m_valid <= 1'b0;
    end else if (load) begin
      m_data  <= asm_buf;
      m_valid <= 1'b1;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_packer.sv
// Directed bench for uart_rx_packer with a 16-bit and a default 576-bit instance.
module tb_uart_rx_packer;

  localparam int unsigned CPP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx16 = 1'b1, rx576 = 1'b1;
  logic m_ready16 = 1'b1, m_ready576 = 1'b1;
  logic [15:0]  m_data16;
  logic [575:0] m_data576;
  logic m_valid16, m_valid576, frame_err16, frame_err576, overflow16, overflow576;

  int checks = 0;
  int errors = 0;
  int err16 = 0, ovf16 = 0, err576 = 0, ovf576 = 0;

  logic [15:0]  q16[$];
  logic [575:0] q576[$];

  always #5 clk = ~clk;

  uart_rx_packer #(.CLOCKS_PER_PULSE(CPP), .BITS_PER_WORD(8), .W_OUT(16)) dut16 (
    .clk(clk), .rst(rst), .rx(rx16), .m_data(m_data16), .m_valid(m_valid16),
    .m_ready(m_ready16), .frame_err(frame_err16), .overflow(overflow16)
  );

  uart_rx_packer #(.CLOCKS_PER_PULSE(CPP), .BITS_PER_WORD(8), .W_OUT(576)) dut576 (
    .clk(clk), .rst(rst), .rx(rx576), .m_data(m_data576), .m_valid(m_valid576),
    .m_ready(m_ready576), .frame_err(frame_err576), .overflow(overflow576)
  );

  task automatic check(input string tag, input logic [575:0] got, input logic [575:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: each handshake pops the oldest expected word.
  logic        hold16 = 1'b0;
  logic [15:0] held16;
  always @(negedge clk) begin
    if (frame_err16)  err16++;
    if (overflow16)   ovf16++;
    if (frame_err576) err576++;
    if (overflow576)  ovf576++;
    if (!rst) begin
      if (hold16) begin
        check("hold_valid16", {575'd0, m_valid16}, 576'd1);
        check("hold_data16", {560'd0, m_data16}, {560'd0, held16});
      end
      hold16 = m_valid16 && !m_ready16;
      held16 = m_data16;
      if (m_valid16 && m_ready16) begin
        check("unexpected16", {544'd0, 32'(q16.size() != 0)}, 576'd1);
        if (q16.size() != 0) check("word16", {560'd0, m_data16}, {560'd0, q16.pop_front()});
      end
      if (m_valid576 && m_ready576) begin
        check("unexpected576", {544'd0, 32'(q576.size() != 0)}, 576'd1);
        if (q576.size() != 0) check("word576", m_data576, q576.pop_front());
      end
    end else begin
      hold16 = 1'b0;
    end
  end

  task automatic drive_bit(input bit big, input logic v);
    #1;
    if (big) rx576 = v; else rx16 = v;
    repeat (CPP) @(posedge clk);
  endtask

  task automatic send_frame(input bit big, input logic [7:0] d, input logic stop);
    drive_bit(big, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(big, d[i]);
    drive_bit(big, stop);
    drive_bit(big, 1'b1);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((q16.size() != 0 || q576.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, {544'd0, 32'(q16.size() + q576.size())}, 576'd0);
  endtask

  initial begin
    logic [575:0] big_exp;
    logic [7:0]   d;
    int e0, o0;

    repeat (3) @(negedge clk);
    check("rst_valid16", {575'd0, m_valid16}, 576'd0);
    check("rst_data16", {560'd0, m_data16}, 576'd0);
    check("rst_ferr16", {575'd0, frame_err16}, 576'd0);
    check("rst_ovf16", {575'd0, overflow16}, 576'd0);
    check("rst_valid576", {575'd0, m_valid576}, 576'd0);
    check("rst_data576", m_data576, 576'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);

    // Single packet
    q16.push_back({8'h3C, 8'hA5});
    send_frame(1'b0, 8'hA5, 1'b1);
    send_frame(1'b0, 8'h3C, 1'b1);
    wait_drain("drain_single", 50);
    check("single_ferr", 576'(err16), 576'd0);
    check("single_ovf", 576'(ovf16), 576'd0);

    // Framing error: bad frame is discarded, packing resumes
    q16.push_back({8'h33, 8'h11});
    send_frame(1'b0, 8'h11, 1'b1);
    send_frame(1'b0, 8'h22, 1'b0);
    send_frame(1'b0, 8'h33, 1'b1);
    wait_drain("drain_ferr", 50);
    check("ferr_count", 576'(err16), 576'd1);

    // One-cycle glitch must not produce a word or error, nor shift alignment
    @(posedge clk); #1 rx16 = 1'b0;
    @(posedge clk); #1 rx16 = 1'b1;
    repeat (30) @(posedge clk);
    check("glitch_ferr", 576'(err16), 576'd1);
    check("glitch_valid", {575'd0, m_valid16}, 576'd0);
    q16.push_back({8'h55, 8'h44});
    send_frame(1'b0, 8'h44, 1'b1);
    send_frame(1'b0, 8'h55, 1'b1);
    wait_drain("drain_glitch", 50);

    // Back-pressure
    o0 = ovf16;
    #1 m_ready16 = 1'b0;
    q16.push_back({8'h02, 8'h01});
    q16.push_back({8'h04, 8'h03});
    for (int i = 1; i <= 6; i++) send_frame(1'b0, 8'(i), 1'b1);
    @(negedge clk);
    check("bp_valid", {575'd0, m_valid16}, 576'd1);
    check("bp_data", {560'd0, m_data16}, {560'd0, 16'h0201});
    check("bp_ovf", 576'(ovf16 - o0), 576'd2);
    @(posedge clk); #1 m_ready16 = 1'b1;
    wait_drain("drain_bp", 20);
    repeat (3) @(negedge clk);
    check("bp_idle", {575'd0, m_valid16}, 576'd0);

    // Reset during the second frame of a packet
    send_frame(1'b0, 8'h66, 1'b1);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b0, 1'b0);
    #1 rst = 1'b1; rx16 = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", {575'd0, m_valid16}, 576'd0);
    check("mid_rst_data", {560'd0, m_data16}, 576'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    q16.push_back({8'h88, 8'h77});
    send_frame(1'b0, 8'h77, 1'b1);
    send_frame(1'b0, 8'h88, 1'b1);
    wait_drain("drain_rst", 50);

    // Full-width packet with random frames and idle gaps
    e0 = err576;
    big_exp = '0;
    for (int i = 0; i < 72; i++) begin
      d = 8'($urandom);
      big_exp[i*8 +: 8] = d;
      if (i == 71) q576.push_back(big_exp);
      send_frame(1'b1, d, 1'b1);
      repeat ($urandom_range(1, 20)) @(posedge clk);
    end
    wait_drain("drain_576", 50);
    check("ferr576", 576'(err576 - e0), 576'd0);
    check("ovf576", 576'(ovf576), 576'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
